sha256_host_loader: RTL and testbench

Host-side initiator for the SHA-256 engine; it drives the engine's start/done handshake and shares the engine's word-addressed memory with it. It performs four steps:
- accepts a raw message as a stream of 32-bit words and writes them into the shared memory at `input_addr`;
- appends standard SHA-256 padding and the 64-bit length;
- pulses `start` to the engine and waits for it to finish;
- reads the 8-word digest back from `hash_addr` and emits it on an output stream.

While the engine runs, the memory port is muxed through to it.

---
 rtl/sha256_host_loader.sv | 141 ++++++++++++++
 tb/tb_sha256_host_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_host_loader.sv
// Host-side initiator for the SHA-256 engine: loads and pads a message into shared
// RAM, runs the engine through its start/done handshake, then streams the digest out.
module sha256_host_loader #(
    parameter int MSG_WORDS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [15:0] input_addr,
    input  logic [15:0] hash_addr,
    output logic        busy,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        sha_start,
    input  logic        sha_done,
    input  logic [15:0] sha_mem_addr,
    input  logic        sha_mem_we,
    input  logic [31:0] sha_mem_wdata,
    output logic [31:0] sha_mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int          PAD_WORDS = 16 * ((MSG_WORDS + 3 + 15) / 16);
    localparam logic [15:0] LAST_MSG  = 16'(MSG_WORDS - 1);
    localparam logic [15:0] LAST_PAD  = 16'(PAD_WORDS - 1);
    localparam logic [31:0] BIT_LEN   = 32'(MSG_WORDS * 32);

    typedef enum logic [2:0] {
        IDLE, LOAD, PAD, START, WAIT_BUSY, WAIT_DONE, FETCH, EMIT
    } state_t;

    state_t      state, state_n;
    logic [15:0] idx;
    logic [2:0]  k;
    logic [15:0] in_base;
    logic [15:0] hash_base;

    // Padding word for message index i; the upper length word is always zero.
    function automatic logic [31:0] pad_word(input logic [15:0] i);
        if (i == 16'(MSG_WORDS))
            return 32'h8000_0000;
        else if (i == LAST_PAD)
            return BIT_LEN;
        else
            return 32'h0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (go) state_n = LOAD;
            LOAD:      if (in_valid && idx == LAST_MSG) state_n = PAD;
            PAD:       if (idx == LAST_PAD) state_n = START;
            START:     state_n = WAIT_BUSY;
            // Engine done is high while idle, so wait for it to drop before watching for its rise.
            WAIT_BUSY: if (!sha_done) state_n = WAIT_DONE;
            WAIT_DONE: if (sha_done) state_n = FETCH;
            FETCH:     state_n = EMIT;
            EMIT:      if (out_valid && out_ready) state_n = (k == 3'd7) ? IDLE : FETCH;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == LOAD);
        sha_start = (state == START);
        out_last  = out_valid && (k == 3'd7);
        mem_addr  = 16'h0;
        mem_we    = 1'b0;
        mem_wdata = 32'h0;
        case (state)
            LOAD: begin
                mem_addr  = in_base + idx;
                mem_we    = in_valid;
                mem_wdata = in_valid ? in_data : 32'h0;
            end
            PAD: begin
                mem_addr  = in_base + idx;
                mem_we    = 1'b1;
                mem_wdata = pad_word(idx);
            end
            START, WAIT_BUSY, WAIT_DONE: begin
                mem_addr  = sha_mem_addr;
                mem_we    = sha_mem_we;
                mem_wdata = sha_mem_wdata;
            end
            FETCH:   mem_addr = hash_base + {13'h0, k};
            default: ;
        endcase
    end

    assign sha_mem_rdata = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 16'h0;
            k         <= 3'd0;
            in_base   <= 16'h0;
            hash_base <= 16'h0;
            out_data  <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    in_base   <= input_addr;
                    hash_base <= hash_addr;
                    idx       <= 16'h0;
                end
                LOAD:      if (in_valid) idx <= idx + 16'd1;
                PAD:       idx <= idx + 16'd1;
                WAIT_DONE: if (sha_done) k <= 3'd0;
                // RAM read data lands in the first EMIT cycle; capture it once and hold it.
                EMIT: begin
                    if (!out_valid) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        k         <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_host_loader.sv
// Scoreboard bench for sha256_host_loader with a stub engine and word-addressed RAM models.
module tb_sha256_host_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go, in_valid, out_ready;
    logic [15:0] input_addr, hash_addr;
    logic [31:0] in_data;

    logic        busy, in_ready, out_valid, out_last, sha_start, sha_done, mem_we;
    logic [31:0] out_data, mem_wdata, mem_rdata, sha_mem_rdata, sha_mem_wdata;
    logic [15:0] mem_addr, sha_mem_addr;
    logic        sha_mem_we;

    logic        busy_b, in_ready_b, out_valid_b, out_last_b, sha_start_b, mem_we_b;
    logic [31:0] out_data_b, mem_wdata_b, mem_rdata_b, sha_mem_rdata_b;
    logic [15:0] mem_addr_b;
    logic        busy_c, in_ready_c, out_valid_c, out_last_c, sha_start_c, mem_we_c;
    logic [31:0] out_data_c, mem_wdata_c, mem_rdata_c, sha_mem_rdata_c;
    logic [15:0] mem_addr_c;

    int checks = 0, errors = 0;

    sha256_host_loader #(.MSG_WORDS(20)) dut (
        .clk(clk), .rst(rst), .go(go), .input_addr(input_addr), .hash_addr(hash_addr),
        .busy(busy), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sha_start(sha_start), .sha_done(sha_done), .sha_mem_addr(sha_mem_addr),
        .sha_mem_we(sha_mem_we), .sha_mem_wdata(sha_mem_wdata), .sha_mem_rdata(sha_mem_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    sha256_host_loader #(.MSG_WORDS(13)) dut_b (
        .clk(clk), .rst(rst), .go(go), .input_addr(input_addr), .hash_addr(hash_addr),
        .busy(busy_b), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .out_ready(1'b1),
        .sha_start(sha_start_b), .sha_done(1'b1), .sha_mem_addr(16'h0),
        .sha_mem_we(1'b0), .sha_mem_wdata(32'h0), .sha_mem_rdata(sha_mem_rdata_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

    sha256_host_loader #(.MSG_WORDS(14)) dut_c (
        .clk(clk), .rst(rst), .go(go), .input_addr(input_addr), .hash_addr(hash_addr),
        .busy(busy_c), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_c),
        .out_valid(out_valid_c), .out_data(out_data_c), .out_last(out_last_c), .out_ready(1'b1),
        .sha_start(sha_start_c), .sha_done(1'b1), .sha_mem_addr(16'h0),
        .sha_mem_we(1'b0), .sha_mem_wdata(32'h0), .sha_mem_rdata(sha_mem_rdata_c),
        .mem_addr(mem_addr_c), .mem_we(mem_we_c), .mem_wdata(mem_wdata_c), .mem_rdata(mem_rdata_c));

    // Synchronous single-port RAMs, read-before-write.
    logic [31:0] ram_a [1024];
    logic [31:0] ram_b [1024];
    logic [31:0] ram_c [1024];
    always @(posedge clk) begin
        if (mem_we) ram_a[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= ram_a[mem_addr[9:0]];
        if (mem_we_b) ram_b[mem_addr_b[9:0]] <= mem_wdata_b;
        mem_rdata_b <= ram_b[mem_addr_b[9:0]];
        if (mem_we_c) ram_c[mem_addr_c[9:0]] <= mem_wdata_c;
        mem_rdata_c <= ram_c[mem_addr_c[9:0]];
    end

    // Stub engine: done high 5 cycles after start, low 10 (writing the digest), then high.
    logic [31:0] dig [8];
    logic [31:0] salt;
    logic [15:0] cur_hash;
    logic [4:0]  eng_cnt;
    logic [2:0]  eng_w;
    initial dig = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    always @(posedge clk or posedge rst) begin
        if (rst)                  eng_cnt <= 5'd0;
        else if (sha_start)       eng_cnt <= 5'd1;
        else if (eng_cnt == 5'd16) eng_cnt <= 5'd0;
        else if (eng_cnt != 5'd0) eng_cnt <= eng_cnt + 5'd1;
    end
    assign eng_w         = 3'(eng_cnt - 5'd6);
    assign sha_done      = !(eng_cnt >= 5'd6 && eng_cnt <= 5'd15);
    assign sha_mem_we    = (eng_cnt >= 5'd6 && eng_cnt <= 5'd13);
    assign sha_mem_addr  = cur_hash + {13'h0, eng_w};
    assign sha_mem_wdata = sha_mem_we ? dig[eng_w] + salt : 32'h0;

    typedef struct { logic [31:0] data; logic last; } exp_t;
    exp_t exp_q [$];

    int start_cnt = 0, start_b = 0, start_c = 0;
    int own_err = 0, early_err = 0, stall_err = 0, stall_low = 0, wcnt = 0;
    logic [31:0] stall_data;
    bit stall_have = 0, stall_arm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (sha_start)   start_cnt++;
            if (sha_start_b) start_b++;
            if (sha_start_c) start_c++;
            if (eng_cnt != 5'd0) begin
                if (mem_we !== sha_mem_we || mem_addr !== sha_mem_addr || mem_wdata !== sha_mem_wdata)
                    own_err++;
                if (out_valid) early_err++;
            end
            if (out_valid && !out_ready) begin
                if (!stall_have) begin stall_data = out_data; stall_have = 1; end
                else if (out_data !== stall_data) stall_err++;
                stall_low++;
            end
            if (out_valid && out_ready) begin
                stall_have = 0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL digest_unexpected actual=%h required=none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("digest_data[%0d]", wcnt % 8), out_data, e.data);
                    chk($sformatf("digest_last[%0d]", wcnt % 8), 32'(out_last), 32'(e.last));
                end
                wcnt++;
            end
        end
    end

    // Output ready driver: optionally holds ready low for 7 valid cycles on digest word 3.
    initial begin
        int sc;
        sc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!stall_arm || (wcnt % 8) != 3) begin sc = 0; out_ready = 1'b1; end
            else if (sc < 7) begin out_ready = 1'b0; if (out_valid) sc++; end
            else out_ready = 1'b1;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_in_ready"},  32'(in_ready), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_last"},  32'(out_last), 0);
        chk({tag, "_sha_start"}, 32'(sha_start), 0);
        chk({tag, "_mem_we"},    32'(mem_we), 0);
        chk({tag, "_out_data"},  out_data, 0);
        chk({tag, "_mem_addr"},  32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic check_image(input logic [15:0] ia, input logic [31:0] dbase);
        logic [31:0] req;
        for (int j = 0; j < 32; j++) begin
            if (j < 20)       req = dbase + 32'(j + 1);
            else if (j == 20) req = 32'h8000_0000;
            else if (j == 31) req = 32'h0000_0280;
            else              req = 32'h0;
            chk($sformatf("img[%0h]", ia + 16'(j)), ram_a[10'(ia + 16'(j))], req);
        end
    endtask

    task automatic run_job(input logic [15:0] ia, input logic [15:0] ha, input logic [31:0] dbase,
                           input bit gaps, input bit poke_go, input int n_words);
        int i, guard;
        bit hs;
        cur_hash = ha;
        if (n_words == 20) begin
            salt = salt + 32'h0100_0000;
            for (int j = 0; j < 8; j++) exp_q.push_back('{data: dig[j] + salt, last: (j == 7)});
        end
        @(posedge clk); #1;
        go = 1'b1; input_addr = ia; hash_addr = ha;
        @(posedge clk); #1;
        go = 1'b0;
        i = 0; guard = 0;
        while (i < n_words && guard < 400) begin
            go = poke_go && (guard == 0);
            input_addr = go ? 16'h0300 : ia;
            hash_addr  = go ? 16'h0300 : ha;
            in_valid   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data    = dbase + 32'(i + 1);
            @(negedge clk);
            if (guard == 0) chk("in_ready_latency", 32'(in_ready), 1);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) i++;
            guard++;
        end
        go = 1'b0; in_valid = 1'b0; input_addr = ia; hash_addr = ha;
        if (i < n_words) begin
            checks++; errors++;
            $display("FAIL load_timeout actual=%0d required=%0d", i, n_words);
        end
        if (n_words == 20) begin
            guard = 0;
            while (busy && guard < 600) begin @(posedge clk); #1; guard++; end
            chk("job_done", 32'(busy), 0);
        end
    endtask

    initial begin
        int sl0;
        rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        input_addr = 16'h0; hash_addr = 16'h0; salt = 32'h0; cur_hash = 16'h0;
        for (int j = 0; j < 1024; j++) begin
            ram_a[j] = 32'hDEADBEEF; ram_b[j] = 32'hDEADBEEF; ram_c[j] = 32'hDEADBEEF;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst_init");
        rst = 1'b0;

        // Basic job; the 13- and 14-word instances load the same stream alongside.
        run_job(16'h0000, 16'h0080, 32'h0, 1'b0, 1'b0, 20);
        check_image(16'h0000, 32'h0);
        chk("start_pulses_1", 32'(start_cnt), 1);
        chk("b_word0",  ram_b[0],  32'h1);
        chk("b_word12", ram_b[12], 32'hD);
        chk("b_pad13",  ram_b[13], 32'h8000_0000);
        chk("b_pad14",  ram_b[14], 32'h0);
        chk("b_len15",  ram_b[15], 32'h0000_01A0);
        chk("b_no16",   ram_b[16], 32'hDEADBEEF);
        chk("b_start",  32'(start_b), 1);
        chk("c_word13", ram_c[13], 32'hE);
        chk("c_pad14",  ram_c[14], 32'h8000_0000);
        chk("c_pad15",  ram_c[15], 32'h0);
        chk("c_pad30",  ram_c[30], 32'h0);
        chk("c_len31",  ram_c[31], 32'h0000_01C0);
        chk("c_no32",   ram_c[32], 32'hDEADBEEF);
        chk("c_start",  32'(start_c), 1);

        // Input gaps, go poked during LOAD, and output stall on word 3.
        sl0 = stall_low;
        stall_arm = 1;
        run_job(16'h0040, 16'h00A0, 32'h1000, 1'b1, 1'b1, 20);
        stall_arm = 0;
        check_image(16'h0040, 32'h1000);
        chk("go_ignored_mem", ram_a[10'h300], 32'hDEADBEEF);
        chk("stall_cycles", 32'(stall_low - sl0), 7);
        chk("stall_stable", 32'(stall_err), 0);
        chk("start_pulses_2", 32'(start_cnt), 2);

        // Reset after word 5, then a fresh job at the same address.
        run_job(16'h0100, 16'h00C0, 32'h2000, 1'b0, 1'b0, 5);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(16'h0100, 16'h00C0, 32'h3000, 1'b0, 1'b0, 20);
        check_image(16'h0100, 32'h3000);
        chk("start_pulses_3", 32'(start_cnt), 3);

        chk("mux_ownership", 32'(own_err), 0);
        chk("fetch_after_done", 32'(early_err), 0);
        chk("digest_all_seen", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
